spi_slave_transmitter: RTL and testbench

- SPI mode-0 slave transmit path: returns bytes from the FPGA to the Raspberry Pi on MISO while the Pi drives SCLK and CS_N. The same SCLK/CS_N also feed spi_slave_receiver.
- Calculator logic pushes bytes into a small TX FIFO through a valid/ready port, e.g. the result word as 4 bytes, MSB byte first.
- The block oversamples SCLK and CS_N on the 50 MHz system clock. It places each bit on MISO before the Pi samples it.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_tx_fifo.sv | 55 +++++
 rtl/spi_slave_transmitter.sv | 152 +++++++++++++++
 tb/tb_spi_slave_transmitter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 slave transmit path.
package spi_pkg;

  typedef enum logic [0:0] {SPI_IDLE, SPI_SHIFT} spi_tx_state_t;

  localparam int SPI_BITS        = 8;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_tx_fifo.sv
// Small synchronous byte FIFO feeding the SPI transmit shift register.
// The head is presented combinationally so a load can pick it up in the same cycle as the pop.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [SPI_BITS-1:0]   din,
  input  logic                  pop,
  output logic [SPI_BITS-1:0]   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SPI_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_slave_transmitter.sv
// SPI mode-0 slave transmitter: oversamples SCLK/CS_N on clk and shifts queued bytes out on MISO.
// MISO changes on SCLK falling edges so it is stable when the master samples on the rising edge.
module spi_slave_transmitter
  import spi_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [SPI_BITS-1:0] IDLE_BYTE  = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_sclk,
  input  logic                        spi_cs_n,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  input  logic [SPI_BITS-1:0]         tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        byte_done,
  output logic                        underrun,
  output logic                        aborted
);

  localparam int                BIT_W     = $clog2(SPI_BITS + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SPI_BITS - 1);
  localparam logic [BIT_W-1:0]  FULL_BITS = BIT_W'(SPI_BITS);

  logic [SPI_SYNC_STAGES:0] sclk_sync;
  logic [SPI_SYNC_STAGES:0] cs_sync;
  logic                     sclk_rise;
  logic                     sclk_fall;
  logic                     cs_fall;
  logic                     cs_rise;

  spi_tx_state_t       state, state_nxt;
  logic [SPI_BITS-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic                load_pending, load_pending_nxt;
  logic                byte_done_nxt;
  logic                underrun_nxt;
  logic                aborted_nxt;

  logic                fifo_push;
  logic                fifo_pop;
  logic [SPI_BITS-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

  // Synchroniser chains carry no reset so a reset taken while CS_N is low cannot fake a cs_fall.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SPI_SYNC_STAGES-1:0], spi_sclk};
    cs_sync   <= {cs_sync[SPI_SYNC_STAGES-1:0], spi_cs_n};
  end

  assign sclk_rise =  sclk_sync[SPI_SYNC_STAGES-1] & ~sclk_sync[SPI_SYNC_STAGES];
  assign sclk_fall = ~sclk_sync[SPI_SYNC_STAGES-1] &  sclk_sync[SPI_SYNC_STAGES];
  assign cs_fall   = ~cs_sync[SPI_SYNC_STAGES-1]   &  cs_sync[SPI_SYNC_STAGES];
  assign cs_rise   =  cs_sync[SPI_SYNC_STAGES-1]   & ~cs_sync[SPI_SYNC_STAGES];

  assign tx_ready  = ~fifo_full;
  assign fifo_push = tx_valid && tx_ready;

  spi_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy        = (state == SPI_SHIFT);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy & shreg[SPI_BITS-1];

  always_comb begin
    state_nxt        = state;
    shreg_nxt        = shreg;
    bit_cnt_nxt      = bit_cnt;
    load_pending_nxt = load_pending;
    fifo_pop         = 1'b0;
    byte_done_nxt    = 1'b0;
    underrun_nxt     = 1'b0;
    aborted_nxt      = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (cs_fall) begin
          fifo_pop         = ~fifo_empty;
          shreg_nxt        = fifo_empty ? IDLE_BYTE : fifo_dout;
          underrun_nxt     = fifo_empty;
          bit_cnt_nxt      = '0;
          load_pending_nxt = 1'b0;
          state_nxt        = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (cs_rise) begin
          aborted_nxt      = (bit_cnt != '0) && (bit_cnt < FULL_BITS);
          load_pending_nxt = 1'b0;
          state_nxt        = SPI_IDLE;
        end else if (sclk_rise) begin
          if (bit_cnt < FULL_BITS) begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              byte_done_nxt    = 1'b1;
              load_pending_nxt = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          // The falling edge that closes a byte reloads instead of shifting, giving gapless bytes.
          if (load_pending) begin
            fifo_pop         = ~fifo_empty;
            shreg_nxt        = fifo_empty ? IDLE_BYTE : fifo_dout;
            underrun_nxt     = fifo_empty;
            bit_cnt_nxt      = '0;
            load_pending_nxt = 1'b0;
          end else begin
            shreg_nxt = {shreg[SPI_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SPI_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      byte_done    <= 1'b0;
      underrun     <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= bit_cnt_nxt;
      load_pending <= load_pending_nxt;
      byte_done    <= byte_done_nxt;
      underrun     <= underrun_nxt;
      aborted      <= aborted_nxt;
    end
  end

endmodule

// File: tb/tb_spi_slave_transmitter.sv
// Directed bench for spi_slave_transmitter: acts as the SPI master and tracks the expected byte stream.
`timescale 1ns/1ps
module tb_spi_slave_transmitter;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       byte_done;
  logic       underrun;
  logic       aborted;

  spi_slave_transmitter #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_BYTE  (IDLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .byte_done   (byte_done),
    .underrun    (underrun),
    .aborted     (aborted)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_bd = 0, n_ur = 0, n_ab = 0;
  int exp_bd = 0, exp_ur = 0, exp_ab = 0;
  int cs_low_cnt = 0, cs_high_cnt = 0;
  bit rst_in_cs = 1'b0;

  // Model: bytes the FIFO should hold, and the bits the master should see next.
  logic [7:0]  m_q[$];
  bit          m_bits[$];
  logic [31:0] rx;
  logic        first_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Per-cycle compare process.
  initial forever begin
    @(negedge clk);
    if (spi_cs_n) begin cs_high_cnt++; cs_low_cnt = 0; end
    else begin cs_low_cnt++; cs_high_cnt = 0; end
    if (byte_done) n_bd++;
    if (underrun)  n_ur++;
    if (aborted)   n_ab++;
    chk("ready_vs_count", {31'd0, tx_ready}, {31'd0, (fifo_count < DEPTH)});
    chk("busy_vs_oe", {31'd0, busy}, {31'd0, spi_miso_oe});
    if (!spi_miso_oe) chk("miso_idle_low", {31'd0, spi_miso}, 32'd0);
    if (cs_high_cnt >= 4) chk("oe_deselected", {31'd0, spi_miso_oe}, 32'd0);
    if (cs_low_cnt >= 4 && !rst_in_cs && !reset) chk("oe_selected", {31'd0, spi_miso_oe}, 32'd1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    if (m_q.size() < DEPTH) m_q.push_back(b);
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic m_load();
    logic [7:0] b;
    if (m_q.size() > 0) b = m_q.pop_front();
    else begin b = IDLE; exp_ur++; end
    for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    rx = '0;
    m_bits.delete();
    m_load();
    step(6);
  endtask

  // mode 0: CS rises after the last fall; 1: CS rises with the last fall; 2: CS stays low.
  task automatic clock_bits(input int n, input int mode);
    bit e;
    for (int i = 0; i < n; i++) begin
      e = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b0;
      chk("miso_bit", {31'd0, spi_miso}, {31'd0, e});
      rx = {rx[30:0], spi_miso};
      if (i == 0) first_ready = tx_ready;
      spi_sclk = 1'b1;
      if (i % 8 == 7) exp_bd++;
      step(4);
      spi_sclk = 1'b0;
      if (i == n - 1 && mode == 1) spi_cs_n = 1'b1;
      else if (i % 8 == 7) m_load();
      step(4);
    end
    if (mode == 0) begin
      spi_cs_n = 1'b1;
      if (n % 8 != 0) exp_ab++;
    end
    if (mode != 2) step(6);
  endtask

  task automatic chk_model();
    chk("byte_done_cnt", n_bd, exp_bd);
    chk("underrun_cnt", n_ur, exp_ur);
    chk("aborted_cnt", n_ab, exp_ab);
    chk("fifo_count_model", {29'd0, fifo_count}, m_q.size());
  endtask

  initial begin
    int   bd0, ur0, ab0, rej;
    logic rdy;

    step(4);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    reset = 1'b0;
    step(2);
    chk("post_rst_pulses", {29'd0, byte_done, underrun, aborted}, 32'd0);
    chk("post_rst_miso", {31'd0, spi_miso}, 32'd0);

    // Single byte
    push(8'hA5);
    chk("single_count_pre", {29'd0, fifo_count}, 32'd1);
    bd0 = n_bd; ur0 = n_ur;
    cs_start();
    chk("single_count_post", {29'd0, fifo_count}, 32'd0);
    clock_bits(8, 1);
    chk("single_rx", {24'd0, rx[7:0]}, 32'h0000_00A5);
    chk("single_bd", n_bd - bd0, 32'd1);
    chk("single_ur", n_ur - ur0, 32'd0);
    chk_model();

    // Burst of four bytes under one CS
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    chk("burst_ready_full", {31'd0, tx_ready}, 32'd0);
    chk("burst_count_full", {29'd0, fifo_count}, 32'd4);
    bd0 = n_bd;
    cs_start();
    clock_bits(32, 1);
    chk("burst_rx", rx, 32'h1234_5678);
    chk("burst_ready_after_load", {31'd0, first_ready}, 32'd1);
    chk("burst_bd", n_bd - bd0, 32'd4);
    chk_model();

    // Underrun
    bd0 = n_bd; ur0 = n_ur;
    cs_start();
    clock_bits(8, 1);
    chk("underrun_rx", {24'd0, rx[7:0]}, 32'h0000_0000);
    chk("underrun_pulse", n_ur - ur0, 32'd1);
    chk("underrun_bd", n_bd - bd0, 32'd1);
    chk_model();

    // Abort after 3 bits, then an empty-FIFO transfer
    push(8'hF0);
    ab0 = n_ab; bd0 = n_bd;
    cs_start();
    clock_bits(3, 0);
    chk("abort_pulse", n_ab - ab0, 32'd1);
    chk("abort_bd", n_bd - bd0, 32'd0);
    chk("abort_rx", {29'd0, rx[2:0]}, 32'd7);
    chk("abort_count", {29'd0, fifo_count}, 32'd0);
    chk_model();
    ur0 = n_ur;
    cs_start();
    clock_bits(8, 1);
    chk("after_abort_rx", {24'd0, rx[7:0]}, 32'h0000_0000);
    chk("after_abort_ur", n_ur - ur0, 32'd1);
    chk_model();

    // Full FIFO with push held across the load pop
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF1);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    spi_cs_n = 1'b0; rx = '0; m_bits.delete(); m_load();
    tx_data = 8'h2B; tx_valid = 1'b1; rej = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = tx_ready;
      step(1);
      if (rdy) break;
      rej++;
    end
    tx_valid = 1'b0;
    m_q.push_back(8'h2B);
    chk("full_push_rejects", rej, 32'd3);
    chk("full_count_after", {29'd0, fifo_count}, 32'd4);
    step(3);
    clock_bits(32, 1);
    chk("full_rx", rx, 32'h9ABC_DEF1);
    chk_model();
    cs_start();
    clock_bits(8, 1);
    chk("full_tail_rx", {24'd0, rx[7:0]}, 32'h0000_002B);
    chk_model();

    // Push landing on the same cycle as the cs_fall load of an empty FIFO
    ur0 = n_ur;
    spi_cs_n = 1'b0; rx = '0; m_bits.delete(); m_load();
    step(2);
    tx_data = 8'h3C; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    m_q.push_back(8'h3C);
    step(3);
    chk("load_push_count", {29'd0, fifo_count}, 32'd1);
    chk("load_push_ur", n_ur - ur0, 32'd1);
    clock_bits(8, 1);
    chk("load_push_rx", {24'd0, rx[7:0]}, 32'h0000_0000);
    chk_model();
    cs_start();
    clock_bits(8, 1);
    chk("load_push_next_rx", {24'd0, rx[7:0]}, 32'h0000_003C);
    chk_model();

    // Reset in the middle of a byte
    push(8'h5A);
    cs_start();
    push(8'h77);
    clock_bits(4, 2);
    bd0 = n_bd; ab0 = n_ab;
    rst_in_cs = 1'b1;
    reset = 1'b1;
    step(1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b0;
    m_q.delete();
    m_bits.delete();
    step(4);
    spi_cs_n = 1'b1;
    step(6);
    rst_in_cs = 1'b0;
    chk("midrst_no_bd", n_bd - bd0, 32'd0);
    chk("midrst_no_ab", n_ab - ab0, 32'd0);
    chk_model();

    ur0 = n_ur;
    cs_start();
    clock_bits(8, 1);
    chk("recover_rx", {24'd0, rx[7:0]}, 32'h0000_0000);
    chk("recover_ur", n_ur - ur0, 32'd1);
    chk_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
